// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : imem_arb_pkg
//  Description : Shared types for the instruction/boot RAM arbiter.
//                state_t - arbiter mode (core running / boot download).
//                src_t   - identifies which requester owns the RAM port.
//                src_is_write - true for sources that write the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

   typedef enum logic [2:0] {
      SRC_NONE   = 3'd0,
      SRC_FETCH  = 3'd1,
      SRC_DREAD  = 3'd2,
      SRC_DWRITE = 3'd3,
      SRC_LOADER = 3'd4
   } src_t;

   function automatic logic src_is_write(input src_t src);
      return (src == SRC_DWRITE) || (src == SRC_LOADER);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_picker.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arb_picker
//  Description : Combinational priority selection of the RAM owner.
//                LOAD : only the boot loader may own the RAM.
//                RUN  : dwrite > dread > fetch, unless fetch is starved,
//                       in which case fetch wins outright.
//  Ports       : state         in  current arbiter mode
//                fetch_starved in  starvation counter reached its limit
//                *_req         in  request lines of the four requesters
//                pick          out selected source (SRC_NONE when idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arb_picker
   import imem_arb_pkg::*;
(
   input  state_t state,
   input  logic   fetch_starved,
   input  logic   fetch_req,
   input  logic   dread_req,
   input  logic   dwrite_req,
   input  logic   loader_req,
   output src_t   pick
);

   always_comb begin
      pick = SRC_NONE;
      if (state == LOAD) begin
         if (loader_req) pick = SRC_LOADER;
      end else begin
         if (fetch_req && fetch_starved) pick = SRC_FETCH;
         else if (dwrite_req)            pick = SRC_DWRITE;
         else if (dread_req)             pick = SRC_DREAD;
         else if (fetch_req)             pick = SRC_FETCH;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_arbiter
//  Description : Shares one synchronous single-port RAM among core fetch,
//                core data read, core data write and the boot loader.
//                The core is held off while a download is in progress and
//                fetch is promoted after STARVE_LIMIT consecutive denials.
//  Ports       : clock, reset                 clock / sync active-high reset
//                fetch_*                       instruction fetch port
//                dread_*                       data read port
//                dwrite_*                      data write port
//                loader_start/done             pulses bracketing a download
//                loader_req/addr/data/gnt      boot loader write port
//                core_hold                     stall to the core (LOAD)
//                mem_en/we/addr/wdata/rdata    RAM interface (1-cycle read)
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 9,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_gnt,
   output logic                  fetch_rvalid,
   output logic [DATA_WIDTH-1:0] fetch_rdata,
   input  logic                  dread_req,
   input  logic [ADDR_WIDTH-1:0] dread_addr,
   output logic                  dread_gnt,
   output logic                  dread_rvalid,
   output logic [DATA_WIDTH-1:0] dread_rdata,
   input  logic                  dwrite_req,
   input  logic [ADDR_WIDTH-1:0] dwrite_addr,
   input  logic [DATA_WIDTH-1:0] dwrite_data,
   output logic                  dwrite_gnt,
   input  logic                  loader_start,
   input  logic                  loader_done,
   input  logic                  loader_req,
   input  logic [ADDR_WIDTH-1:0] loader_addr,
   input  logic [DATA_WIDTH-1:0] loader_data,
   output logic                  loader_gnt,
   output logic                  core_hold,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   state_t                  state;
   logic [CNT_W-1:0]        starve_cnt;
   src_t                    pick;
   src_t                    sel;
   src_t                    last_src;
   logic [DATA_WIDTH-1:0]   fetch_held;
   logic [DATA_WIDTH-1:0]   dread_held;

   imem_arb_picker u_picker (
      .state         (state),
      .fetch_starved (starve_cnt == STARVE_MAX),
      .fetch_req     (fetch_req),
      .dread_req     (dread_req),
      .dwrite_req    (dwrite_req),
      .loader_req    (loader_req),
      .pick          (pick)
   );

   // Grants are combinational, so reset must mask them directly to keep the
   // RAM quiet while reset is asserted.
   assign sel = reset ? SRC_NONE : pick;

   assign fetch_gnt  = (sel == SRC_FETCH);
   assign dread_gnt  = (sel == SRC_DREAD);
   assign dwrite_gnt = (sel == SRC_DWRITE);
   assign loader_gnt = (sel == SRC_LOADER);

   assign mem_en    = (sel != SRC_NONE);
   assign mem_we    = src_is_write(sel);
   assign core_hold = !reset && (state == LOAD);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      case (sel)
         SRC_FETCH:  mem_addr = fetch_addr;
         SRC_DREAD:  mem_addr = dread_addr;
         SRC_DWRITE: begin
            mem_addr  = dwrite_addr;
            mem_wdata = dwrite_data;
         end
         SRC_LOADER: begin
            mem_addr  = loader_addr;
            mem_wdata = loader_data;
         end
         default: ;
      endcase
   end

   // A read issued in the cycle reset rises must not surface, hence the
   // reset term on the return path as well.
   assign fetch_rvalid = !reset && (last_src == SRC_FETCH);
   assign dread_rvalid = !reset && (last_src == SRC_DREAD);
   assign fetch_rdata  = reset ? '0 : (fetch_rvalid ? mem_rdata : fetch_held);
   assign dread_rdata  = reset ? '0 : (dread_rvalid ? mem_rdata : dread_held);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= RUN;
         starve_cnt <= '0;
         last_src   <= SRC_NONE;
         fetch_held <= '0;
         dread_held <= '0;
      end else begin
         case (state)
            RUN:     if (loader_start) state <= LOAD;
            LOAD:    if (loader_done)  state <= RUN;
            default: state <= RUN;
         endcase

         if (state == LOAD || !fetch_req || fetch_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + CNT_W'(1);

         last_src <= sel;
         if (fetch_rvalid) fetch_held <= mem_rdata;
         if (dread_rvalid) dread_held <= mem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_arbiter
//  Description : Directed self-checking bench for imem_arbiter with a
//                behavioural synchronous single-port RAM attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          fetch_req, dread_req, dwrite_req, loader_req;
   logic [AW-1:0] fetch_addr, dread_addr, dwrite_addr, loader_addr;
   logic [DW-1:0] dwrite_data, loader_data;
   logic          loader_start, loader_done;
   logic          fetch_gnt, fetch_rvalid, dread_gnt, dread_rvalid;
   logic          dwrite_gnt, loader_gnt, core_hold;
   logic [DW-1:0] fetch_rdata, dread_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          ram_init;
   logic [DW-1:0] ram [512];

   int vectors = 0;
   int miscompares = 0;

   imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_gnt    (fetch_gnt),
      .fetch_rvalid (fetch_rvalid),
      .fetch_rdata  (fetch_rdata),
      .dread_req    (dread_req),
      .dread_addr   (dread_addr),
      .dread_gnt    (dread_gnt),
      .dread_rvalid (dread_rvalid),
      .dread_rdata  (dread_rdata),
      .dwrite_req   (dwrite_req),
      .dwrite_addr  (dwrite_addr),
      .dwrite_data  (dwrite_data),
      .dwrite_gnt   (dwrite_gnt),
      .loader_start (loader_start),
      .loader_done  (loader_done),
      .loader_req   (loader_req),
      .loader_addr  (loader_addr),
      .loader_data  (loader_data),
      .loader_gnt   (loader_gnt),
      .core_hold    (core_hold),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clock = ~clock;

   // Behavioural RAM: word i preloads to 0xC0000000|i, word 0x010 holds NOP.
   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 512; i++)
            ram[i] <= (i == 16) ? 32'h0000_0013 : (32'hC000_0000 | DW'(i));
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata    <= ram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;  ram_init = 1'b1;
      fetch_req = 0; dread_req = 0; dwrite_req = 0; loader_req = 0;
      fetch_addr = '0; dread_addr = '0; dwrite_addr = '0; loader_addr = '0;
      dwrite_data = '0; loader_data = '0;
      loader_start = 0; loader_done = 0;
      tick();
      ram_init = 1'b0;
      fetch_req = 1'b1; fetch_addr = 9'h010;
      #1;
      check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
      check("rst_mem_en",    32'(mem_en),    32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_core_hold", 32'(core_hold), 32'd0);
      tick();
      reset = 1'b0; fetch_req = 1'b0;
      #1;
      check("idle_rvalid",   32'(fetch_rvalid | dread_rvalid), 32'd0);
      check("idle_fdata",    fetch_rdata, 32'd0);
      check("idle_mem_en",   32'(mem_en), 32'd0);

      // Single fetch, one-cycle read return, held value afterwards.
      fetch_req = 1'b1; fetch_addr = 9'h010;
      #1;
      check("f1_gnt",    32'(fetch_gnt), 32'd1);
      check("f1_memaddr", 32'(mem_addr), 32'h010);
      check("f1_we",     32'(mem_we),    32'd0);
      check("f1_others", 32'({dread_gnt, dwrite_gnt, loader_gnt}), 32'd0);
      tick();
      fetch_req = 1'b0;
      #1;
      check("f1_rvalid", 32'(fetch_rvalid), 32'd1);
      check("f1_rdata",  fetch_rdata, 32'h0000_0013);
      check("f1_drv",    32'(dread_rvalid), 32'd0);
      tick();
      check("f1_rv_drop", 32'(fetch_rvalid), 32'd0);
      check("f1_held",    fetch_rdata, 32'h0000_0013);

      // Priority and starvation: dwrite, then dread held with fresh
      // addresses; fetch must win on its 5th denied cycle.
      dwrite_req = 1'b1; dwrite_addr = 9'h020; dwrite_data = 32'hDEAD_BEEF;
      dread_req = 1'b1;  dread_addr = 9'h024;
      fetch_req = 1'b1;  fetch_addr = 9'h010;
      #1;
      check("p_dw_gnt",  32'(dwrite_gnt), 32'd1);
      check("p_dw_we",   32'(mem_we), 32'd1);
      check("p_dw_data", mem_wdata, 32'hDEAD_BEEF);
      check("p_f_deny",  32'(fetch_gnt | dread_gnt), 32'd0);
      tick();
      dwrite_req = 1'b0;
      for (int c = 2; c <= 4; c++) begin
         #1;
         check($sformatf("p_dr_gnt%0d", c), 32'(dread_gnt), 32'd1);
         check($sformatf("p_f_deny%0d", c), 32'(fetch_gnt), 32'd0);
         tick();
         if (c == 2) check("p_dr_data", dread_rdata, 32'hC000_0024);
      end
      #1;
      check("p_starve_gnt", 32'(fetch_gnt), 32'd1);
      check("p_starve_dr",  32'(dread_gnt), 32'd0);
      tick();
      fetch_req = 1'b0; dread_req = 1'b0;
      #1;
      check("p_f_rdata", fetch_rdata, 32'h0000_0013);

      // Write then immediate read of the same word.
      dwrite_req = 1'b1; dwrite_addr = 9'h030; dwrite_data = 32'h1234_5678;
      tick();
      dwrite_req = 1'b0; dread_req = 1'b1; dread_addr = 9'h030;
      #1;
      check("wr_rd_gnt", 32'(dread_gnt), 32'd1);
      tick();
      dread_req = 1'b0;
      #1;
      check("wr_rd_rv",   32'(dread_rvalid), 32'd1);
      check("wr_rd_data", dread_rdata, 32'h1234_5678);

      // Download: core held off, loader owns the RAM.
      loader_start = 1'b1;
      tick();
      loader_start = 1'b0; fetch_req = 1'b1; fetch_addr = 9'h000;
      #1;
      check("ld_hold", 32'(core_hold), 32'd1);
      for (int i = 0; i < 4; i++) begin
         loader_req = 1'b1; loader_addr = AW'(i); loader_data = 32'hA0 + i;
         #1;
         check($sformatf("ld_gnt%0d", i),   32'(loader_gnt), 32'd1);
         check($sformatf("ld_fgnt%0d", i),  32'(fetch_gnt),  32'd0);
         check($sformatf("ld_hold%0d", i),  32'(core_hold),  32'd1);
         tick();
      end
      loader_req = 1'b0; loader_done = 1'b1;
      #1;
      check("ld_done_fgnt", 32'(fetch_gnt), 32'd0);
      tick();
      loader_done = 1'b0;
      #1;
      check("ld_unhold", 32'(core_hold), 32'd0);
      for (int i = 0; i < 4; i++) begin
         fetch_addr = AW'(i);
         #1;
         check($sformatf("lf_gnt%0d", i), 32'(fetch_gnt), 32'd1);
         tick();
         check($sformatf("lf_data%0d", i), fetch_rdata, 32'hA0 + i);
      end
      fetch_req = 1'b0;

      // Reset the cycle after a dread grant discards the return.
      dread_req = 1'b1; dread_addr = 9'h030;
      #1;
      check("rr_gnt", 32'(dread_gnt), 32'd1);
      tick();
      dread_req = 1'b0; reset = 1'b1;
      #1;
      check("rr_rv_in_rst",   32'(dread_rvalid), 32'd0);
      check("rr_data_in_rst", dread_rdata, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("rr_rv_after",   32'(dread_rvalid), 32'd0);
      check("rr_data_after", dread_rdata, 32'd0);
      check("rr_fdata_after", fetch_rdata, 32'd0);
      fetch_req = 1'b1; fetch_addr = 9'h010;
      #1;
      check("rr_run_fgnt", 32'(fetch_gnt), 32'd1);
      tick();
      fetch_req = 1'b0;

      // Simultaneous start/done pulses act by state.
      loader_start = 1'b1; loader_done = 1'b1;
      tick();
      loader_start = 1'b0; loader_done = 1'b0;
      #1;
      check("both_run_to_load", 32'(core_hold), 32'd1);
      loader_start = 1'b1; loader_done = 1'b1;
      tick();
      loader_start = 1'b0; loader_done = 1'b0;
      #1;
      check("both_load_to_run", 32'(core_hold), 32'd0);
      check("idle_mem_addr",    32'(mem_addr), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
